spike_pool_scanner: RTL and testbench



---
 rtl/spike_pool_scanner_pkg.sv | 26 ++
 rtl/spike_pool_scanner_if.sv | 33 +++
 rtl/spike_pool_scanner_lif_channel_update.sv | 25 ++
 rtl/spike_pool_scanner.sv | 170 +++++++++++++++++
 tb/tb_spike_pool_scanner.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_pool_scanner_pkg.sv
// Shared types and defaults for the pooling scanner: FSM state encoding,
// pooled-event layout and default LIF parameters.
package spike_pool_scanner_pkg;

  localparam int          DEFAULT_THRESHOLD   = 64;
  localparam int unsigned DEFAULT_DECAY_SHIFT = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StEmit,
    StDone
  } pool_state_t;

  // Event layout at the default 4-channel / 8-bit-coordinate configuration.
  localparam int unsigned EvChannels  = 4;
  localparam int unsigned EvCoordBits = 8;

  typedef struct packed {
    logic [EvChannels-1:0]  mask;
    logic [EvCoordBits-1:0] y;
    logic [EvCoordBits-1:0] x;
  } pool_event_t;

endpackage

// File: rtl/spike_pool_scanner_if.sv
// Feature-map BRAM port and output-FIFO push port of the pooling scanner.
// master = scanner side, slave = memory/FIFO side.
interface spike_pool_scanner_if #(
  parameter int unsigned COORD_BITS       = 8,
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned BITS_PER_CHANNEL = 8
);
  localparam int unsigned DataW = CHANNELS * BITS_PER_CHANNEL;
  localparam int unsigned OutW  = CHANNELS + 2 * COORD_BITS;

  logic                  rd_en;
  logic [COORD_BITS-1:0] rd_x;
  logic [COORD_BITS-1:0] rd_y;
  logic [DataW-1:0]      rd_data;
  logic                  wr_en;
  logic [COORD_BITS-1:0] wr_x;
  logic [COORD_BITS-1:0] wr_y;
  logic [DataW-1:0]      wr_data;
  logic                  out_full;
  logic                  out_valid;
  logic [OutW-1:0]       out_data;

  modport master (
    output rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, out_valid, out_data,
    input  rd_data, out_full
  );

  modport slave (
    input  rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data, out_valid, out_data,
    output rd_data, out_full
  );

endinterface

// File: rtl/spike_pool_scanner_lif_channel_update.sv
// Combinational leak-and-fire update of one signed membrane channel.
module lif_channel_update
  import spike_pool_scanner_pkg::*;
#(
  parameter int unsigned BITS_PER_CHANNEL = 8,
  parameter int          THRESHOLD        = DEFAULT_THRESHOLD,
  parameter int unsigned DECAY_SHIFT      = DEFAULT_DECAY_SHIFT
) (
  input  logic signed [BITS_PER_CHANNEL-1:0] v,
  output logic signed [BITS_PER_CHANNEL-1:0] new_v,
  output logic                               spike
);

  localparam logic signed [BITS_PER_CHANNEL-1:0] Thr = BITS_PER_CHANNEL'(THRESHOLD);

  logic signed [BITS_PER_CHANNEL-1:0] leaked;

  // v - (v >>> k) moves v toward zero by at most |v|, so it cannot overflow.
  always_comb begin
    leaked = v - (v >>> DECAY_SHIFT);
    spike  = (leaked >= Thr);
    new_v  = spike ? '0 : leaked;
  end

endmodule

// File: rtl/spike_pool_scanner.sv
// Raster-scans the feature map in 2x2 windows, applies LIF to every pixel with
// read/writeback, and pushes one OR-ed spike-mask event per window that fired.
module spike_pool_scanner
  import spike_pool_scanner_pkg::*;
#(
  parameter int unsigned COORD_BITS       = 8,
  parameter int unsigned IMG_WIDTH        = 32,
  parameter int unsigned IMG_HEIGHT       = 32,
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned BITS_PER_CHANNEL = 8,
  parameter int          THRESHOLD        = DEFAULT_THRESHOLD,
  parameter int unsigned DECAY_SHIFT      = DEFAULT_DECAY_SHIFT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        start,
  output logic                        ready,
  output logic                        active,
  output logic                        done,
  spike_pool_scanner_if.master        bus
);

  localparam int unsigned DataW = CHANNELS * BITS_PER_CHANNEL;
  localparam int unsigned WinX  = IMG_WIDTH / 2;
  localparam int unsigned WinY  = IMG_HEIGHT / 2;

  if ((IMG_WIDTH % 2) != 0) begin : gen_bad_width
    $error("IMG_WIDTH must be even");
  end
  if ((IMG_HEIGHT % 2) != 0) begin : gen_bad_height
    $error("IMG_HEIGHT must be even");
  end

  pool_state_t           state_q, state_d;
  logic [COORD_BITS-1:0] wx_q, wx_d, wy_q, wy_d;
  logic [COORD_BITS-1:0] last_x_q, last_y_q;
  logic [1:0]            phase_q, phase_d;
  logic [CHANNELS-1:0]   mask_q, mask_d, spikes;
  logic                  start_pend_q, start_pend_d;
  logic                  hold_q, hold_d;
  logic [COORD_BITS-1:0] px, py;
  logic [DataW-1:0]      new_v;
  logic                  rd_en, wr_en, push, last_win;

  for (genvar c = 0; c < CHANNELS; c++) begin : gen_lif
    lif_channel_update #(
      .BITS_PER_CHANNEL(BITS_PER_CHANNEL),
      .THRESHOLD       (THRESHOLD),
      .DECAY_SHIFT     (DECAY_SHIFT)
    ) u_lif (
      .v    (bus.rd_data[c*BITS_PER_CHANNEL +: BITS_PER_CHANNEL]),
      .new_v(new_v[c*BITS_PER_CHANNEL +: BITS_PER_CHANNEL]),
      .spike(spikes[c])
    );
  end

  assign px       = COORD_BITS'({wx_q, phase_q[0]});
  assign py       = COORD_BITS'({wy_q, phase_q[1]});
  assign last_win = (wx_q == COORD_BITS'(WinX - 1)) && (wy_q == COORD_BITS'(WinY - 1));

  always_comb begin
    state_d      = state_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    phase_d      = phase_q;
    start_pend_d = start_pend_q;
    hold_d       = hold_q;
    ready        = 1'b0;
    done         = 1'b0;
    rd_en        = 1'b0;
    push         = 1'b0;
    // Writeback trails each read by one cycle, onto the address read last cycle.
    wr_en        = ((state_q == StRead) && (phase_q != 2'd0)) || (state_q == StDrain);

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start_pend_q && enable) begin
          state_d      = StRead;
          wx_d         = '0;
          wy_d         = '0;
          phase_d      = 2'd0;
          start_pend_d = 1'b0;
        end else if (start) begin
          start_pend_d = 1'b1;
        end
      end
      StRead: begin
        rd_en   = 1'b1;
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) state_d = StDrain;
      end
      StDrain: begin
        state_d = StEmit;
        hold_d  = 1'b0;
      end
      StEmit: begin
        if (hold_q) begin
          // Window already emitted and advanced; only waiting for enable.
          if (enable) begin
            state_d = StRead;
            hold_d  = 1'b0;
          end
        end else if ((mask_q == '0) || !bus.out_full) begin
          push = (mask_q != '0);
          if (last_win) begin
            state_d = StDone;
            wx_d    = '0;
            wy_d    = '0;
          end else begin
            if (wx_q == COORD_BITS'(WinX - 1)) begin
              wx_d = '0;
              wy_d = wy_q + 1'b1;
            end else begin
              wx_d = wx_q + 1'b1;
            end
            if (enable) state_d = StRead;
            else        hold_d  = 1'b1;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StRead) && (phase_q == 2'd0)) mask_d = '0;
    else if (wr_en)                                mask_d = mask_q | spikes;
    else                                           mask_d = mask_q;
  end

  assign active        = (state_q != StIdle);
  assign bus.rd_en     = rd_en;
  assign bus.rd_x      = rd_en ? px : '0;
  assign bus.rd_y      = rd_en ? py : '0;
  assign bus.wr_en     = wr_en;
  assign bus.wr_x      = wr_en ? last_x_q : '0;
  assign bus.wr_y      = wr_en ? last_y_q : '0;
  assign bus.wr_data   = wr_en ? new_v : '0;
  assign bus.out_valid = push;
  assign bus.out_data  = push ? {mask_q, wy_q, wx_q} : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wx_q         <= '0;
      wy_q         <= '0;
      phase_q      <= 2'd0;
      mask_q       <= '0;
      start_pend_q <= 1'b0;
      hold_q       <= 1'b0;
      last_x_q     <= '0;
      last_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      phase_q      <= phase_d;
      mask_q       <= mask_d;
      start_pend_q <= start_pend_d;
      hold_q       <= hold_d;
      last_x_q     <= px;
      last_y_q     <= py;
    end
  end

endmodule

// File: tb/tb_spike_pool_scanner.sv
// Directed bench for spike_pool_scanner on a 4x4, 2-channel map with a BRAM
// model, an arithmetic LIF/pooling reference and a per-cycle output checker.
module tb_spike_pool_scanner;

  localparam int unsigned Cb = 8;
  localparam int unsigned Ch = 2;
  localparam int unsigned Bpc = 8;

  logic clk = 1'b0;
  logic reset, enable, start;
  logic ready, active, done;

  spike_pool_scanner_if #(.COORD_BITS(Cb), .CHANNELS(Ch), .BITS_PER_CHANNEL(Bpc)) bus ();

  spike_pool_scanner #(
    .COORD_BITS      (Cb),
    .IMG_WIDTH       (4),
    .IMG_HEIGHT      (4),
    .CHANNELS        (Ch),
    .BITS_PER_CHANNEL(Bpc),
    .THRESHOLD       (64),
    .DECAY_SHIFT     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .start (start),
    .ready (ready),
    .active(active),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read, write at the clock edge, bulk preload.
  logic [15:0] mem [16];
  logic [15:0] init_mem [16];
  logic [15:0] rd_q;
  logic        load_req;
  assign bus.rd_data = rd_q;

  always @(posedge clk) begin
    if (load_req) begin
      mem <= init_mem;
    end else begin
      if (bus.rd_en) rd_q <= mem[bus.rd_y * 4 + bus.rd_x];
      if (bus.wr_en) mem[bus.wr_y * 4 + bus.wr_x] <= bus.wr_data;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model
  logic [15:0] img [16];
  logic [15:0] exp_mem [16];
  logic [15:0] exp_reads[$];
  logic [17:0] exp_events[$];
  logic [17:0] got_events[$];

  function automatic int leak(input int v);
    int fl;
    fl = (v < 0) ? -((-v + 3) / 4) : v / 4;  // floor(v/4)
    return v - fl;
  endfunction

  task automatic build_expect();
    exp_reads.delete();
    exp_events.delete();
    got_events.delete();
    exp_mem = img;
    for (int wy = 0; wy < 2; wy++) begin
      for (int wx = 0; wx < 2; wx++) begin
        logic [1:0] m;
        m = 2'b00;
        for (int p = 0; p < 4; p++) begin
          int x, y, idx;
          x = 2 * wx + p % 2;
          y = 2 * wy + p / 2;
          idx = y * 4 + x;
          exp_reads.push_back({8'(y), 8'(x)});
          for (int c = 0; c < 2; c++) begin
            logic [7:0] b;
            int l;
            b = img[idx][c*8 +: 8];
            l = leak(int'($signed(b)));
            if (l >= 64) begin
              m[c] = 1'b1;
              exp_mem[idx][c*8 +: 8] = 8'd0;
            end else begin
              exp_mem[idx][c*8 +: 8] = 8'(l);
            end
          end
        end
        if (m != 2'b00) exp_events.push_back({m, 8'(wy), 8'(wx)});
      end
    end
  endtask

  // Per-cycle output checker
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("ready_vs_active", ready, !active);
        if (bus.rd_en) begin
          check("read_expected", exp_reads.size() != 0, 1);
          if (exp_reads.size() != 0) check("rd_addr", {bus.rd_y, bus.rd_x}, exp_reads.pop_front());
        end else begin
          check("rd_idle", {bus.rd_y, bus.rd_x}, 0);
        end
        if (bus.wr_en) check("rd_wr_same_addr",
                             bus.rd_en && ({bus.rd_y, bus.rd_x} == {bus.wr_y, bus.wr_x}), 0);
        else           check("wr_idle", {bus.wr_y, bus.wr_x, bus.wr_data}, 0);
        if (bus.out_valid) begin
          check("push_while_full", bus.out_full, 0);
          check("event_expected", exp_events.size() != 0, 1);
          if (exp_events.size() != 0) check("event", bus.out_data, exp_events.pop_front());
          got_events.push_back(bus.out_data);
        end else begin
          check("out_idle", bus.out_data, 0);
        end
      end
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 16'h0000;
  endtask

  task automatic load_image();
    init_mem = img;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // Starts a scan and runs it to done. Cycle 0 is the cycle start is high.
  task automatic run_scan(input string tag, input int stall_end, input int en_off,
                          input int en_on, input int start_again, input int q_lo,
                          input int q_hi, input int exp_cycles);
    int cnt;
    bit seen;
    load_image();
    build_expect();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 1;
    seen = 1'b0;
    while (!seen && cnt <= 300) begin
      bus.out_full = (cnt < stall_end);
      enable       = !(cnt >= en_off && cnt < en_on);
      start        = (cnt == start_again);
      @(negedge clk);
      if (cnt >= q_lo && cnt <= q_hi) check({tag, "_rd_paused"}, bus.rd_en, 0);
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1 cnt++;
      end
    end
    check({tag, "_done_cycle"}, cnt, exp_cycles);
    bus.out_full = 1'b0;
    enable = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check({tag, "_idle_after_done"}, {ready, done, bus.rd_en}, 3'b100);
    end
    check({tag, "_events_left"}, exp_events.size(), 0);
    check({tag, "_reads_left"}, exp_reads.size(), 0);
    for (int i = 0; i < 16; i++) check({tag, "_mem"}, mem[i], exp_mem[i]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    start = 1'b0;
    load_req = 1'b0;
    bus.out_full = 1'b0;
    clear_img();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {ready, active, done, bus.rd_en, bus.wr_en, bus.out_valid}, 6'b100000);
    @(posedge clk);
    #1 reset = 1'b0;

    // All zero: nothing fires, 6*4+2 cycles.
    clear_img();
    run_scan("zero", 0, 0, 0, 0, 1, 0, 26);
    check("zero_events", got_events.size(), 0);

    // (1,1) ch0=100 leaks to 75 and fires.
    clear_img();
    img[5] = 16'h0064;
    run_scan("single", 0, 0, 0, 0, 1, 0, 26);
    check("single_mem", mem[5], 16'h0000);
    check("single_count", got_events.size(), 1);
    if (got_events.size() != 0) check("single_event", got_events[0], 18'h10000);

    // (2,3) ch1=-40 leaks to -30, no event.
    clear_img();
    img[14] = 16'hD800;
    run_scan("neg", 0, 0, 0, 0, 1, 0, 26);
    check("neg_mem", mem[14], 16'hE200);
    check("neg_events", got_events.size(), 0);

    // (3,3) ch0=88, ch1=90 both fire; FIFO full through cycle 29 stalls EMIT 5 cycles.
    clear_img();
    img[15] = 16'h5A58;
    run_scan("stall", 30, 0, 0, 0, 1, 0, 31);
    check("stall_mem", mem[15], 16'h0000);
    check("stall_count", got_events.size(), 1);
    if (got_events.size() != 0) check("stall_event", got_events[0], 18'h30101);

    // Threshold boundary: 85 -> 64 fires, 84 -> 63 does not.
    clear_img();
    img[0] = 16'h0055;
    img[2] = 16'h0054;
    run_scan("bound", 0, 0, 0, 0, 1, 0, 26);
    check("bound_mem00", mem[0], 16'h0000);
    check("bound_mem20", mem[2], 16'h003F);
    check("bound_count", got_events.size(), 1);
    if (got_events.size() != 0) check("bound_event", got_events[0], 18'h10000);

    // enable low in cycles 10..19 (mid window 1): window finishes, reads pause 14..20.
    clear_img();
    img[5] = 16'h0064;
    run_scan("pause", 0, 10, 20, 0, 14, 20, 33);

    // start pulsed while active is ignored.
    clear_img();
    img[14] = 16'hD800;
    run_scan("restart", 0, 0, 0, 5, 1, 0, 26);

    // Reset during window 1 aborts; a fresh start rescans from (0,0).
    clear_img();
    img[5] = 16'h0064;
    load_image();
    build_expect();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_abort", {ready, active, done, bus.rd_en, bus.wr_en, bus.out_valid}, 6'b100000);
    @(posedge clk);
    #1;
    run_scan("rescan", 0, 0, 0, 0, 1, 0, 26);
    check("rescan_mem", mem[5], 16'h0000);
    check("rescan_count", got_events.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
